// File: rtl/mitchell_logmul_pipe_pkg.sv
// Shared constants, payload types and the log-domain adder helper for the
// Mitchell approximate 8x8 multiplier back end.
package mitchell_logmul_pipe_pkg;

    localparam int K_W    = 3;
    localparam int FRAC_W = 7;
    localparam int OP_W   = 2 ** K_W;
    localparam int OUT_W  = 2 * OP_W;
    localparam int LSUM_W = K_W + 1 + FRAC_W;

    // Log sum: integer part widened by one bit so the fraction carry lands in k.
    typedef struct packed {
        logic [K_W:0]      k;
        logic [FRAC_W-1:0] f;
    } log_sum_t;

    typedef logic [OUT_W-1:0] prod_t;

    // Payload carried from the log-add stage into the antilog stage.
    typedef struct packed {
        log_sum_t l;
        logic     zr;
    } s1_payload_t;

    // Payload carried from the antilog stage into the output stage.
    typedef struct packed {
        prod_t p;
        logic  zr;
    } s2_payload_t;

    // Adds two fixed-point logarithms {k, f}; the fraction carry propagates into k.
    function automatic log_sum_t log_add(
        input logic [K_W-1:0]    k_a,
        input logic [FRAC_W-1:0] f_a,
        input logic [K_W-1:0]    k_b,
        input logic [FRAC_W-1:0] f_b
    );
        logic [LSUM_W-1:0] sum;
        sum = {1'b0, k_a, f_a} + {1'b0, k_b, f_b};
        return log_sum_t'(sum);
    endfunction

endpackage

// File: rtl/mitchell_logmul_pipe_if.sv
// Operand/product handshake bundle for mitchell_logmul_pipe.
// slave: the pipeline's view; master: the driver/consumer side.
interface mitchell_logmul_pipe_if
    import mitchell_logmul_pipe_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [K_W-1:0]    k_a;
    logic [K_W-1:0]    k_b;
    logic [FRAC_W:0]   x_a;
    logic [FRAC_W:0]   x_b;
    logic              z_a;
    logic              z_b;
    logic              out_valid;
    logic              out_ready;
    prod_t             prod;

    modport slave (
        input  in_valid, k_a, k_b, x_a, x_b, z_a, z_b, out_ready,
        output in_ready, out_valid, prod
    );

    modport master (
        output in_valid, k_a, k_b, x_a, x_b, z_a, z_b, out_ready,
        input  in_ready, out_valid, prod
    );

endinterface

// File: rtl/mitchell_logmul_pipe_antilog.sv
// Combinational antilog: p = {1, f} scaled by 2**(k - FRAC_W), truncated.
module mitchell_antilog
    import mitchell_logmul_pipe_pkg::*;
(
    input  log_sum_t i_l,
    output prod_t    o_p
);

    localparam logic [K_W:0] C_BIAS = (K_W + 1)'(FRAC_W);

    logic [OUT_W-1:0] w_m;

    assign w_m = {{(OUT_W - FRAC_W - 1){1'b0}}, 1'b1, i_l.f};

    // Shift the restored mantissa left or right depending on the characteristic.
    always_comb begin
        o_p = '0;
        if (i_l.k >= C_BIAS) begin
            o_p = w_m << (i_l.k - C_BIAS);
        end else begin
            o_p = w_m >> (C_BIAS - i_l.k);
        end
    end

endmodule

// File: rtl/mitchell_logmul_pipe.sv
// Mitchell log-domain multiplier back end: log add -> antilog -> output,
// three registered stages with valid/ready on both sides.
// Optional feature macro: LOGMUL_PERF_EN adds the perf_cnt completed-product counter.
module mitchell_logmul_pipe
    import mitchell_logmul_pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    mitchell_logmul_pipe_if.slave  bus
`ifdef LOGMUL_PERF_EN
    ,
    output logic [31:0]            perf_cnt
`endif
);

    logic        r_v1;
    logic        r_v2;
    logic        r_v3;
    s1_payload_t r_s1;
    s2_payload_t r_s2;
    prod_t       r_prod;

    logic        w_rdy1;
    logic        w_rdy2;
    logic        w_rdy3;
    s1_payload_t w_s1_next;
    prod_t       w_p;
    logic        w_unused_msb;

    // Detector fractions carry a constant-zero MSB that plays no part in the sum.
    assign w_unused_msb = bus.x_a[FRAC_W] | bus.x_b[FRAC_W];

    // A stage can load when it is empty or its successor takes its content now.
    assign w_rdy3 = !r_v3 || bus.out_ready;
    assign w_rdy2 = !r_v2 || w_rdy3;
    assign w_rdy1 = !r_v1 || w_rdy2;

    assign bus.in_ready  = w_rdy1;
    assign bus.out_valid = r_v3;
    assign bus.prod      = r_prod;

    // Log-add of the two operands plus the combined zero flag.
    always_comb begin
        w_s1_next    = '0;
        w_s1_next.l  = log_add(bus.k_a, bus.x_a[FRAC_W-1:0],
                               bus.k_b, bus.x_b[FRAC_W-1:0]);
        w_s1_next.zr = bus.z_a | bus.z_b;
    end

    mitchell_antilog u_antilog (
        .i_l (r_s1.l),
        .o_p (w_p)
    );

    // Stage 1: capture the log sum of an accepted operand pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_rdy1) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1 <= w_s1_next;
            end
        end
    end

    // Stage 2: capture the antilog of the stage-1 log sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_s2 <= '0;
        end else if (w_rdy2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2.p  <= w_p;
                r_s2.zr <= r_s1.zr;
            end
        end
    end

    // Stage 3: output register; a zero operand forces the product to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3   <= 1'b0;
            r_prod <= '0;
        end else if (w_rdy3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_prod <= r_s2.zr ? '0 : r_s2.p;
            end
        end
    end

`ifdef LOGMUL_PERF_EN
    logic [31:0] r_perf;

    // Count completed output transfers, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= 32'd0;
        end else if (r_v3 && bus.out_ready && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cnt = r_perf;
`endif

endmodule
